// File: rtl/avr_irq_pkg.sv
// Shared types and constants for the AVR interrupt controller.
package avr_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  localparam logic [1:0] ADDR_IPEND = 2'd0;
  localparam logic [1:0] ADDR_IMASK = 2'd1;
  localparam logic [1:0] ADDR_IVEC  = 2'd2;
  localparam logic [1:0] ADDR_ICTL  = 2'd3;

  localparam int GIE_BIT = 7;

endpackage

// File: rtl/avr_irq_ctrl_if.sv
// I/O bus and CPU request/ack/reti signals of the interrupt controller.
interface avr_irq_ctrl_if;
  // I/O bus: a write happens when io_we & ~io_re. A read is combinational on
  // io_re. The core takes a request by pulsing cpu_ack for one cycle while
  // cpu_irq=1, and pulses cpu_reti for one cycle when its handler returns.
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic       cpu_irq;
  logic [2:0] cpu_vector;
  logic       cpu_ack;
  logic       cpu_reti;

  modport master (
    output io_re, io_we, io_a, io_di, cpu_ack, cpu_reti,
    input  io_do, cpu_irq, cpu_vector
  );

  modport slave (
    input  io_re, io_we, io_a, io_di, cpu_ack, cpu_reti,
    output io_do, cpu_irq, cpu_vector
  );
endinterface

// File: rtl/avr_irq_prio.sv
// Combinational priority encoder: lowest set index wins.
module avr_irq_prio #(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic             any,
  output logic [2:0]       index
);

  always_comb begin
    any   = |req;
    index = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// AVR I/O-bus interrupt controller: pending latch, mask, priority, CPU handshake.
// Optional AVR_IRQCTL_EDGE_EN adds per-source edge-sensitive pending (ICTL[N_IRQ-1:0]).
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  avr_irq_ctrl_if.slave    bus,
  input  logic [N_IRQ-1:0] irq_in,
  output irq_state_t       state_dbg
);

  irq_state_t       state, state_nxt;
  logic [N_IRQ-1:0] ipend, ipend_nxt, imask;
  logic [N_IRQ-1:0] pend_set, pend_clr, active;
  logic             gie;
  logic [2:0]       vector_q;
  logic             vec_load;
  logic             act_any;
  logic [2:0]       win_idx;

  logic wr, wr_ipend, wr_imask, wr_ictl, gie_clr, ack_take;

  assign wr       = bus.io_we & ~bus.io_re;
  assign wr_ipend = wr && (bus.io_a == ADDR_IPEND);
  assign wr_imask = wr && (bus.io_a == ADDR_IMASK);
  assign wr_ictl  = wr && (bus.io_a == ADDR_ICTL);
  assign gie_clr  = wr_ictl & ~bus.io_di[GIE_BIT];
  assign ack_take = (state == REQ) & bus.cpu_ack;

  assign active = ipend & imask & {N_IRQ{gie}};

  avr_irq_prio #(.N_IRQ(N_IRQ)) u_prio (
    .req   (active),
    .any   (act_any),
    .index (win_idx)
  );

`ifdef AVR_IRQCTL_EDGE_EN
  // Bit 7 of ICTL is GIE, so it can never be an edge-select bit.
  localparam logic [7:0] EDGE_MASK8 = 8'h7F;
  logic [N_IRQ-1:0] edge_q, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      irq_q  <= '0;
    end else begin
      irq_q <= irq_in;
      if (wr_ictl) edge_q <= bus.io_di[N_IRQ-1:0] & EDGE_MASK8[N_IRQ-1:0];
    end
  end

  assign pend_set = (irq_in & ~irq_q & edge_q) | (irq_in & ~edge_q);
`else
  assign pend_set = irq_in;
`endif

  // A source asserting in the same cycle as a clear keeps its pending bit.
  always_comb begin
    pend_clr = '0;
    if (wr_ipend) pend_clr = bus.io_di[N_IRQ-1:0];
    for (int i = 0; i < N_IRQ; i++) begin
      if (ack_take && (vector_q == 3'(i))) pend_clr[i] = 1'b1;
    end
    ipend_nxt = (ipend & ~pend_clr) | pend_set;
  end

  always_comb begin
    state_nxt = state;
    vec_load  = 1'b0;
    case (state)
      IDLE: if (act_any && !gie_clr) begin
        state_nxt = REQ;
        vec_load  = 1'b1;
      end
      REQ: begin
        if (bus.cpu_ack)  state_nxt = SVC;
        else if (gie_clr) state_nxt = IDLE;
      end
      SVC: if (bus.cpu_reti) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ipend    <= '0;
      imask    <= '0;
      gie      <= 1'b0;
      vector_q <= 3'd0;
    end else begin
      state <= state_nxt;
      ipend <= ipend_nxt;
      if (wr_imask) imask    <= bus.io_di[N_IRQ-1:0];
      if (wr_ictl)  gie      <= bus.io_di[GIE_BIT];
      if (vec_load) vector_q <= win_idx;
    end
  end

  logic [7:0] ipend8, imask8, ivec8, ictl8;

  always_comb begin
    ipend8 = 8'h00;
    imask8 = 8'h00;
    ictl8  = 8'h00;
    ipend8[N_IRQ-1:0] = ipend;
    imask8[N_IRQ-1:0] = imask;
`ifdef AVR_IRQCTL_EDGE_EN
    ictl8[N_IRQ-1:0] = edge_q;
`endif
    ictl8[GIE_BIT] = gie;
    ivec8 = {(state == SVC), 4'b0000, vector_q};

    bus.io_do = 8'h00;
    if (bus.io_re) begin
      case (bus.io_a)
        ADDR_IPEND: bus.io_do = ipend8;
        ADDR_IMASK: bus.io_do = imask8;
        ADDR_IVEC:  bus.io_do = ivec8;
        default:    bus.io_do = ictl8;
      endcase
    end
  end

  assign bus.cpu_irq    = (state == REQ);
  assign bus.cpu_vector = vector_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Directed bench for avr_irq_ctrl; the edge-mode step runs when AVR_IRQCTL_EDGE_EN is defined.
module tb_avr_irq_ctrl;
  import avr_irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  irq_state_t state_dbg;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  avr_irq_ctrl_if bus ();

  avr_irq_ctrl #(.N_IRQ(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .irq_in    (irq_in),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [1:0] a, input logic [7:0] d);
    bus.io_we = 1'b1;
    bus.io_a  = a;
    bus.io_di = d;
    tick();
    bus.io_we = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
  endtask

  // scoreboard: expected value queued, then popped against the observation
  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: observed=%02h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%02h expected=%02h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] e);
    bus.io_re = 1'b1;
    bus.io_a  = a;
    #1;
    exp_q.push_back(e);
    chk(tag, bus.io_do);
    bus.io_re = 1'b0;
  endtask

  task automatic sig(input string tag, input logic [7:0] obs, input logic [7:0] e);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask

  initial begin
    bus.io_re = 1'b0; bus.io_we = 1'b0; bus.io_a = 2'd0; bus.io_di = 8'h00;
    bus.cpu_ack = 1'b0; bus.cpu_reti = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;

    // reset state
    rd("rst_ipend", ADDR_IPEND, 8'h00);
    rd("rst_imask", ADDR_IMASK, 8'h00);
    rd("rst_ivec",  ADDR_IVEC,  8'h00);
    rd("rst_ictl",  ADDR_ICTL,  8'h00);
    sig("rst_irq", {7'b0, bus.cpu_irq}, 8'h00);
    sig("rst_state", {6'b0, state_dbg}, 8'h00);

    // ack outside REQ is ignored
    pulse_ack();
    sig("ack_idle_state", {6'b0, state_dbg}, 8'h00);

    // basic request
    io_wr(ADDR_IMASK, 8'h01);
    io_wr(ADDR_ICTL, 8'h80);
    rd("ctl_rb", ADDR_ICTL, 8'h80);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    sig("basic_irq_k1", {7'b0, bus.cpu_irq}, 8'h00);
    rd("basic_pend", ADDR_IPEND, 8'h01);
    tick();
    sig("basic_irq_k2", {7'b0, bus.cpu_irq}, 8'h01);
    sig("basic_vec", {5'b0, bus.cpu_vector}, 8'h00);
    pulse_ack();
    sig("basic_irq_ack", {7'b0, bus.cpu_irq}, 8'h00);
    rd("basic_pend_ack", ADDR_IPEND, 8'h00);
    rd("basic_ivec_svc", ADDR_IVEC, 8'h80);
    pulse_reti();
    rd("basic_ivec_reti", ADDR_IVEC, 8'h00);

    // priority
    io_wr(ADDR_IMASK, 8'hFF);
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    tick();
    sig("prio_irq", {7'b0, bus.cpu_irq}, 8'h01);
    sig("prio_vec2", {5'b0, bus.cpu_vector}, 8'h02);
    pulse_ack();
    rd("prio_pend", ADDR_IPEND, 8'h20);
    tick();
    sig("prio_held_svc", {7'b0, bus.cpu_irq}, 8'h00);
    pulse_reti();
    sig("prio_gap", {7'b0, bus.cpu_irq}, 8'h00);
    tick();
    sig("prio_irq2", {7'b0, bus.cpu_irq}, 8'h01);
    sig("prio_vec5", {5'b0, bus.cpu_vector}, 8'h05);
    pulse_ack();
    pulse_reti();
    rd("prio_pend_end", ADDR_IPEND, 8'h00);

    // masking and W1C, including set-wins on a same-cycle clear
    io_wr(ADDR_IMASK, 8'h00);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    rd("mask_pend", ADDR_IPEND, 8'h08);
    sig("mask_noirq", {7'b0, bus.cpu_irq}, 8'h00);
    io_wr(ADDR_IPEND, 8'h08);
    rd("w1c_pend", ADDR_IPEND, 8'h00);
    irq_in = 8'h08;
    io_wr(ADDR_IPEND, 8'h08);
    rd("w1c_setwins", ADDR_IPEND, 8'h08);
    irq_in = 8'h00;
    io_wr(ADDR_IPEND, 8'h08);
    rd("w1c_pend2", ADDR_IPEND, 8'h00);

    // vector stability, reti outside SVC, GIE drop
    io_wr(ADDR_IMASK, 8'hFF);
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    sig("stab_vec4", {5'b0, bus.cpu_vector}, 8'h04);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    sig("stab_vec_hold", {5'b0, bus.cpu_vector}, 8'h04);
    io_wr(ADDR_IMASK, 8'h00);
    sig("stab_vec_mask", {5'b0, bus.cpu_vector}, 8'h04);
    sig("stab_irq", {7'b0, bus.cpu_irq}, 8'h01);
    pulse_reti();
    sig("reti_req_state", {6'b0, state_dbg}, 8'h01);
    rd("stab_pend", ADDR_IPEND, 8'h11);
    io_wr(ADDR_ICTL, 8'h00);
    sig("gie_drop_irq", {7'b0, bus.cpu_irq}, 8'h00);
    sig("gie_drop_state", {6'b0, state_dbg}, 8'h00);

    // reset while in SVC
    io_wr(ADDR_IMASK, 8'hFF);
    io_wr(ADDR_ICTL, 8'h80);
    tick();
    sig("svc_irq", {7'b0, bus.cpu_irq}, 8'h01);
    sig("svc_vec0", {5'b0, bus.cpu_vector}, 8'h00);
    pulse_ack();
    sig("svc_state", {6'b0, state_dbg}, 8'h02);
    bus.io_a = ADDR_IVEC;
    #1;
    sig("do_no_re", bus.io_do, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sig("rst2_state", {6'b0, state_dbg}, 8'h00);
    rd("rst2_pend", ADDR_IPEND, 8'h00);
    rd("rst2_mask", ADDR_IMASK, 8'h00);
    rd("rst2_ivec", ADDR_IVEC, 8'h00);
    rd("rst2_ictl", ADDR_ICTL, 8'h00);

    // level mode: held line re-pends after ack, new request after reti
    io_wr(ADDR_IMASK, 8'h01);
    io_wr(ADDR_ICTL, 8'h80);
    irq_in = 8'h01;
    tick();
    tick();
    sig("lvl_irq", {7'b0, bus.cpu_irq}, 8'h01);
    pulse_ack();
    rd("lvl_repend", ADDR_IPEND, 8'h01);
    pulse_reti();
    tick();
    sig("lvl_irq2", {7'b0, bus.cpu_irq}, 8'h01);
    irq_in = 8'h00;
    pulse_ack();
    pulse_reti();
    io_wr(ADDR_IPEND, 8'hFF);

`ifdef AVR_IRQCTL_EDGE_EN
    // edge mode: a held-high line pends once
    io_wr(ADDR_ICTL, 8'h81);
    rd("edge_ictl", ADDR_ICTL, 8'h81);
    irq_in = 8'h01;
    tick();
    tick();
    sig("edge_irq", {7'b0, bus.cpu_irq}, 8'h01);
    pulse_ack();
    rd("edge_nopend", ADDR_IPEND, 8'h00);
    pulse_reti();
    tick();
    tick();
    sig("edge_noirq", {7'b0, bus.cpu_irq}, 8'h00);
    rd("edge_nopend2", ADDR_IPEND, 8'h00);
    irq_in = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
